// File: rtl/chip8_pkg.sv
// Shared constants and encodings for the CHIP-8 style memory responder.
// Holds the state encoding, default address map and storage geometry.
package chip8_pkg;
  localparam int ADDR_W   = 12;
  localparam int MEM_SIZE = 4096;
  localparam int FONT_LEN = 80;

  localparam logic [ADDR_W-1:0] C8_FONT_BASE  = 12'h000;
  localparam logic [ADDR_W-1:0] C8_PROT_LIMIT = 12'h200;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD_LO, ST_RESP} state_t;

  // What the held response describes; selects how rsp_data is formed.
  typedef enum logic [1:0] {K_BYTE, K_WORD, K_WRITE} kind_t;
endpackage

// File: rtl/chip8_font_rom.sv
// Combinational ROM holding the standard 0-F hex digit sprites, 5 bytes each.
// Indices past the last sprite byte return zero.
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] i_idx,
  output logic [7:0] o_byte
);
  localparam logic [7:0] ROM [FONT_LEN] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

  always_comb begin
    o_byte = 8'h00;
    if (i_idx < 7'(FONT_LEN)) o_byte = ROM[i_idx];
  end
endmodule

// File: rtl/mem_responder.sv
// 4 KiB single-port byte memory behind a one-outstanding valid/ready request port.
// Preloads the font after reset, serves byte/word reads and write-protected byte writes.
module mem_responder
  import chip8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FONT_BASE  = C8_FONT_BASE,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = C8_PROT_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic              rsp_err,
  output logic              init_done
);
  state_t            r_state, w_next;
  kind_t             r_kind;
  logic [6:0]        r_init_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_hi;
  logic [7:0]        r_rd_q;
  logic [7:0]        r_mem [MEM_SIZE];

  logic              w_accept;
  logic              w_prot;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [7:0]        w_mem_wdata;
  logic [7:0]        w_font_byte;

  chip8_font_rom u_font (
    .i_idx  (r_init_cnt),
    .o_byte (w_font_byte)
  );

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_prot   = req_addr < PROT_LIMIT;

  // The single memory port is steered by state: font fill, request, or low-byte fetch.
  always_comb begin
    w_next      = r_state;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_addr  = r_addr;
    w_mem_wdata = req_wdata;
    case (r_state)
      ST_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = FONT_BASE + {5'd0, r_init_cnt};
        w_mem_wdata = w_font_byte;
        if (r_init_cnt == 7'(FONT_LEN - 1)) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          w_mem_addr = req_addr;
          if (req_we) begin
            w_mem_we = !w_prot;
            w_next   = ST_RESP;
          end else begin
            w_mem_re = 1'b1;
            w_next   = req_word ? ST_RD_LO : ST_RESP;
          end
        end
      end
      ST_RD_LO: begin
        w_mem_addr = r_addr + 12'd1;
        w_mem_re   = 1'b1;
        w_next     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
    if (rst) begin
      w_next   = ST_INIT;
      w_mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    if (w_mem_re) r_rd_q <= r_mem[w_mem_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 7'd0;
      r_kind     <= K_BYTE;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_hi       <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 7'd1;
      if (w_accept) begin
        r_addr <= req_addr;
        r_err  <= req_we && w_prot;
        r_kind <= req_we ? K_WRITE : (req_word ? K_WORD : K_BYTE);
      end
      if (r_state == ST_RD_LO) r_hi <= r_rd_q;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign init_done = (r_state != ST_INIT);
  assign rsp_err   = (r_state == ST_RESP) && r_err;

  always_comb begin
    rsp_data = 16'h0000;
    if (r_state == ST_RESP) begin
      case (r_kind)
        K_BYTE:  rsp_data = {8'h00, r_rd_q};
        K_WORD:  rsp_data = {r_hi, r_rd_q};
        default: rsp_data = 16'h0000;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array-based memory model.
// Covers init timing, font contents, protection, wrap, backpressure and reset mid-transfer.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_word = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        init_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] font_m [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90, 8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  // Reference memory: only locations the bench knows the contents of are read back.
  logic [7:0] mem_m [4096];
  bit         known [4096];

  mem_responder #(.FONT_BASE(12'h000), .PROT_LIMIT(12'h200)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic load_font_model();
    for (int i = 0; i < 80; i++) begin
      mem_m[i] = font_m[i];
      known[i] = 1'b1;
    end
  endtask

  // Drives one request to completion; lat counts edges from accept to rsp_valid.
  task automatic do_req(input logic we, input logic word, input logic [11:0] a,
                        input logic [7:0] d, output logic [15:0] data,
                        output logic err, output int lat, output bit ok);
    int n = 0;
    ok = 1'b1; lat = 0; data = '0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_word = word; req_addr = a; req_wdata = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      ok = 1'b0;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      ok = 1'b0;
      return;
    end
    data = rsp_data;
    err  = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int cyc = 0;
    while (cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      if (init_done) break;
    end
    n_cmp++;
    if (cyc !== 80) begin
      n_bad++;
      $display("FAIL %s init_cycles got %0d want 80", name, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, init_done} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%h err=%b done=%b want all zero",
               req_ready, rsp_valid, rsp_data, rsp_err, init_done);
    end
    rst = 1'b0;
    wait_init("reset");
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ready got %b want 1", req_ready);
    end
    load_font_model();
  endtask

  task automatic test_font();
    logic [15:0] d; logic e; int lat; bit ok;
    logic [11:0] a;
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 12'h000 : (i == 1) ? 12'h04F : 12'($urandom_range(0, 79));
      do_req(1'b0, 1'b0, a, 8'h00, d, e, lat, ok);
      n_cmp++;
      if (!ok || d !== {8'h00, mem_m[a]} || lat !== 1 || e !== 1'b0) begin
        n_bad++;
        $display("FAIL font_read addr=%h got ok=%b data=%h lat=%0d err=%b want data=%h lat=1",
                 a, ok, d, lat, e, {8'h00, mem_m[a]});
      end
    end
  endtask

  task automatic test_word_rw();
    logic [15:0] d; logic e; int lat; bit ok;
    do_req(1'b1, 1'b0, 12'h200, 8'hA2, d, e, lat, ok);
    mem_m[12'h200] = 8'hA2; known[12'h200] = 1'b1;
    do_req(1'b1, 1'b0, 12'h201, 8'h2A, d, e, lat, ok);
    mem_m[12'h201] = 8'h2A; known[12'h201] = 1'b1;
    n_cmp++;
    if (!ok || e !== 1'b0 || d !== 16'h0000) begin
      n_bad++;
      $display("FAIL write_rsp got ok=%b err=%b data=%h want err=0 data=0000", ok, e, d);
    end
    do_req(1'b0, 1'b1, 12'h200, 8'h00, d, e, lat, ok);
    n_cmp++;
    if (!ok || d !== 16'hA22A || lat !== 2 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL word_read got ok=%b data=%h lat=%0d err=%b want A22A lat=2 err=0",
               ok, d, lat, e);
    end
  endtask

  task automatic test_protect();
    logic [15:0] d; logic e; int lat; bit ok;
    do_req(1'b1, 1'b0, 12'h1FF, 8'h55, d, e, lat, ok);
    n_cmp++;
    if (!ok || e !== 1'b1 || d !== 16'h0000) begin
      n_bad++;
      $display("FAIL prot_1ff got ok=%b err=%b data=%h want err=1 data=0000", ok, e, d);
    end
    do_req(1'b1, 1'b0, 12'h04F, 8'h55, d, e, lat, ok);
    n_cmp++;
    if (!ok || e !== 1'b1) begin
      n_bad++;
      $display("FAIL prot_04f got ok=%b err=%b want err=1", ok, e);
    end
    do_req(1'b0, 1'b0, 12'h04F, 8'h00, d, e, lat, ok);
    n_cmp++;
    if (!ok || d !== 16'h0080) begin
      n_bad++;
      $display("FAIL prot_unchanged got ok=%b data=%h want 0080", ok, d);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] d; logic e; int lat; bit ok;
    do_req(1'b1, 1'b0, 12'hFFF, 8'h12, d, e, lat, ok);
    mem_m[12'hFFF] = 8'h12; known[12'hFFF] = 1'b1;
    do_req(1'b0, 1'b1, 12'hFFF, 8'h00, d, e, lat, ok);
    n_cmp++;
    if (!ok || d !== 16'h12F0 || lat !== 2) begin
      n_bad++;
      $display("FAIL word_wrap got ok=%b data=%h lat=%0d want 12F0 lat=2", ok, d, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] d, exp_d; logic e, exp_e; int lat, exp_lat; bit ok;
    logic [11:0] a;
    logic [7:0]  wd;
    int op;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      a = 12'($urandom_range(0, 4095));
      if (op == 0) begin
        wd = 8'($urandom);
        exp_e = (a < 12'h200);
        exp_d = 16'h0000; exp_lat = 1;
        do_req(1'b1, 1'b0, a, wd, d, e, lat, ok);
        if (!exp_e) begin
          mem_m[a] = wd; known[a] = 1'b1;
        end
      end else begin
        for (int t = 0; t < 400; t++) begin
          if (known[a] && (op == 1 || known[12'(a + 12'd1)])) break;
          a = (t < 399) ? 12'($urandom_range(0, 4095)) : 12'h000;
        end
        exp_e = 1'b0;
        exp_d = (op == 1) ? {8'h00, mem_m[a]} : {mem_m[a], mem_m[12'(a + 12'd1)]};
        exp_lat = op;
        do_req(1'b0, op == 2, a, 8'h00, d, e, lat, ok);
      end
      n_cmp++;
      if (!ok || d !== exp_d || e !== exp_e || lat !== exp_lat) begin
        n_bad++;
        $display("FAIL random op=%0d addr=%h got ok=%b data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                 op, a, ok, d, e, lat, exp_d, exp_e, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d; logic e; int lat; bit ok;
    do_req(1'b1, 1'b0, 12'h300, 8'h11, d, e, lat, ok);
    mem_m[12'h300] = 8'h11; known[12'h300] = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_word = 1'b0; req_addr = 12'h000;
    @(posedge clk);
    #1 req_we = 1'b1; req_addr = 12'h300; req_wdata = 8'h77;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h00F0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall cyc=%0d got vld=%b data=%h err=%b rdy=%b want 1 00F0 0 0",
                 c, rsp_valid, rsp_data, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL consume got vld=%b want 0", rsp_valid);
    end
    do_req(1'b0, 1'b0, 12'h300, 8'h00, d, e, lat, ok);
    n_cmp++;
    if (!ok || d !== {8'h00, mem_m[12'h300]}) begin
      n_bad++;
      $display("FAIL no_second_accept got ok=%b data=%h want %h", ok, d, {8'h00, mem_m[12'h300]});
    end
  endtask

  task automatic test_rst_rd_lo();
    logic [15:0] d; logic e; int lat; bit ok;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_word = 1'b1; req_addr = 12'h200;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_rd_lo got vld=%b done=%b rdy=%b data=%h want 0 0 0 0000",
               rsp_valid, init_done, req_ready, rsp_data);
    end
    wait_init("rst_rd_lo");
    do_req(1'b0, 1'b1, 12'h200, 8'h00, d, e, lat, ok);
    n_cmp++;
    if (!ok || d !== {mem_m[12'h200], mem_m[12'h201]}) begin
      n_bad++;
      $display("FAIL kept_storage got ok=%b data=%h want %h", ok, d, {mem_m[12'h200], mem_m[12'h201]});
    end
    do_req(1'b0, 1'b0, 12'h04F, 8'h00, d, e, lat, ok);
    n_cmp++;
    if (!ok || d !== 16'h0080) begin
      n_bad++;
      $display("FAIL font_reload got ok=%b data=%h want 0080", ok, d);
    end
  endtask

  initial begin
    test_reset();
    test_font();
    test_word_rw();
    test_protect();
    test_wrap();
    test_random();
    test_backpressure();
    test_rst_rd_lo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter FONT_BASE, default 12'h000, byte address where the font sprites are loaded at init.
REQ-002 SHALL have parameter PROT_LIMIT, default 12'h200; writes to addresses below it are rejected.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  initiator (CPU) presents a request.
REQ-007 req_ready  out  1  responder accepts a request this cycle.
REQ-008 req_we  in  1  1 = byte write, 0 = read.
REQ-009 req_word  in  1  read width: 1 = 16-bit big-endian word, 0 = byte; ignored when req_we=1.
REQ-010 req_addr  in  12  byte address.
REQ-011 req_wdata  in  8  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  initiator consumes the response.
REQ-014 rsp_data  out  16  read data; byte reads are zero-extended; 16'h0000 for writes.
REQ-015 rsp_err  out  1  write rejected as protected.
REQ-016 init_done  out  1  font preload complete.

Function
REQ-017 SHALL hold 4096 x 8-bit storage with synchronous single-port access: one byte per cycle.
REQ-018 SHALL implement states INIT, IDLE, RD_LO, RESP.
REQ-019 INIT: copy the 80 font bytes, index 0..79, to FONT_BASE+index, one per cycle, over 80 cycles; req_ready=0; init_done=0; then go to IDLE with init_done=1.
REQ-020 IDLE: req_ready=1; a transfer is accepted only when req_valid && req_ready.
REQ-021 Accepted byte read: memory read issued on the accept edge; go to RESP; rsp_valid=1 on the next cycle with rsp_data={8'h00, mem[addr]}.
REQ-022 Accepted word read: high byte read on the accept edge; go to RD_LO; low byte read from (addr+1) mod 4096; go to RESP; rsp_valid=1 two cycles after accept with rsp_data={mem[addr], mem[addr+1]}.
REQ-023 Word read at 12'hFFF SHALL wrap: low byte comes from 12'h000.
REQ-024 Accepted write with addr >= PROT_LIMIT: byte stored on the accept edge; response rsp_err=0.
REQ-025 Accepted write with addr < PROT_LIMIT: storage unchanged; response rsp_err=1.
REQ-026 RESP: rsp_valid, rsp_data and rsp_err SHALL stay stable until rsp_ready=1; on rsp_valid && rsp_ready go to IDLE; req_ready stays 0 until the next cycle (one outstanding request at most).
REQ-027 req_* inputs SHALL be ignored outside IDLE; there is no queueing.
REQ-028 A read after a write to the same address SHALL return the new data.

Reset
REQ-029 rst=1 at any cycle, including mid-INIT, RD_LO or RESP: next state INIT, init counter=0, req_ready=0, rsp_valid=0, rsp_data=16'h0000, rsp_err=0, init_done=0.
REQ-030 Any in-flight response SHALL be discarded on reset; storage outside the font region is not cleared.

Structure
REQ-031 A shared package chip8_pkg SHALL hold the state encoding, FONT_BASE, PROT_LIMIT, memory size 4096 and font length 80.
REQ-032 The font SHALL be a sub-module chip8_font_rom: combinational 7-bit index in, 8-bit byte out, holding the standard 0-F 5-byte sprites.

Verification
REQ-033 Reset, then count cycles -> init_done rises exactly 80 cycles after rst falls; a byte read at 12'h000 returns 16'h00F0 and at 12'h04F returns 16'h0080.
REQ-034 Write 8'hA2 to 12'h200 and 8'h2A to 12'h201, then word read at 12'h200 -> rsp_data=16'hA22A, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-035 Write 8'h55 to 12'h1FF -> rsp_err=1; a byte read at 12'h1FF returns its prior value.
REQ-036 Write 8'h12 to 12'hFFF, then word read at 12'hFFF -> rsp_data={8'h12, mem[12'h000]}=16'h12F0.
REQ-037 Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_* stable, req_ready=0, no second accept; the response is consumed on the first rsp_ready=1.
REQ-038 Assert rst during RD_LO -> the next cycle rsp_valid=0, init_done=0, and INIT restarts.
